// File: rtl/aes_rkey_store.sv
// aes_rkey_store: round-key store for AES.
// Keys are appended in schedule order, and the store reports full once NK
// keys (11/13/15, picked by key_len) are loaded. Reads return one cycle later.
// Optional feature: define RKEY_REVERSE_RD_EN to add the rd_dir port, which
// reads the store in decryption order.
module aes_rkey_store #(
    parameter int DATA_W   = 128,
    parameter int MAX_KEYS = 15,
    parameter int AW       = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              clr,
    input  logic [1:0]        key_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_req,
    input  logic [AW-1:0]     rd_addr,
`ifdef RKEY_REVERSE_RD_EN
    input  logic              rd_dir,
`endif
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_err,
    output logic              full,
    output logic [AW-1:0]     count
);

    typedef enum logic [1:0] {EMPTY, LOADING, FULL} state_t;

    typedef struct packed {
        logic              vld;
        logic              err;
        logic [DATA_W-1:0] data;
    } rd_rsp_t;

    // Number of round keys for a key-length code.
    function automatic logic [AW-1:0] nk_of(input logic [1:0] kl);
        case (kl)
            2'b00:   nk_of = AW'(11);
            2'b01:   nk_of = AW'(13);
            default: nk_of = AW'(15);
        endcase
    endfunction

    state_t            state_q, state_d;
    logic [AW-1:0]     count_q;
    logic [1:0]        kl_q;
    logic              alive_q;
    logic [DATA_W-1:0] mem [MAX_KEYS];
    rd_rsp_t           rsp_q, rsp_d;

    logic              wr_fire;
    logic [AW-1:0]     nk_cur;
    logic [AW:0]       phys;
    logic              rd_hit;

    // Before the first key is accepted, the live key_len decides NK, because the
    // latched copy is loaded on that same edge.
    assign nk_cur   = (count_q == '0) ? nk_of(key_len) : nk_of(kl_q);
    // alive_q keeps wr_ready low during reset and lets it rise on the first edge after release.
    assign wr_ready = alive_q && (state_q != FULL) && !clr;
    assign wr_fire  = wr_valid && wr_ready;
    assign full     = (state_q == FULL);
    assign count    = count_q;
    assign rd_valid = rsp_q.vld;
    assign rd_err   = rsp_q.err;
    assign rd_data  = rsp_q.data;

    // Compute the physical index one bit wider so that a reverse index below zero
    // shows up as bit AW set.
`ifdef RKEY_REVERSE_RD_EN
    assign phys = rd_dir ? ({1'b0, nk_of(kl_q)} - (AW+1)'(1) - {1'b0, rd_addr})
                         : {1'b0, rd_addr};
`else
    assign phys = {1'b0, rd_addr};
`endif
    // The range check uses the count from before any write in the same cycle.
    assign rd_hit = !phys[AW] && (phys[AW-1:0] < count_q);

    // Next state of the FSM. clr takes priority over a write.
    always_comb begin
        state_d = state_q;
        if (clr)
            state_d = EMPTY;
        else if (wr_fire)
            state_d = ((count_q + AW'(1)) == nk_cur) ? FULL : LOADING;
    end

    // Read response for the next cycle. rd_data holds its value between responses.
    always_comb begin
        rsp_d      = rsp_q;
        rsp_d.vld  = 1'b0;
        rsp_d.err  = 1'b0;
        if (rd_req) begin
            rsp_d.vld  = 1'b1;
            rsp_d.err  = clr || !rd_hit;
            rsp_d.data = (!clr && rd_hit) ? mem[phys[AW-1:0]] : '0;
        end
    end

    // State register, fill count, latched key length and the alive flag after reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= EMPTY;
            count_q <= '0;
            kl_q    <= 2'b00;
            alive_q <= 1'b0;
        end else begin
            alive_q <= 1'b1;
            state_q <= state_d;
            if (clr) begin
                count_q <= '0;
                kl_q    <= 2'b00;
            end else if (wr_fire) begin
                count_q <= count_q + AW'(1);
                if (count_q == '0) kl_q <= key_len;
            end
        end
    end

    // Key storage. clr zeroes every entry, and an accepted write appends at mem[count].
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < MAX_KEYS; i++) mem[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < MAX_KEYS; i++) mem[i] <= '0;
        end else if (wr_fire) begin
            mem[count_q] <= wr_data;
        end
    end

    // Read response register. Reset drops any response still in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) rsp_q <= '0;
        else         rsp_q <= rsp_d;
    end

endmodule

// File: tb/tb_aes_rkey_store.sv
// Directed testbench for aes_rkey_store. It has checks for the optional
// RKEY_REVERSE_RD_EN build as well.
module tb_aes_rkey_store;
    localparam int DW = 128;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          clr = 1'b0;
    logic [1:0]    key_len = 2'b00;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [DW-1:0] wr_data = '0;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
`ifdef RKEY_REVERSE_RD_EN
    logic          rd_dir = 1'b0;
`endif
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_err;
    logic          full;
    logic [AW-1:0] count;

    int n_tests = 0;
    int n_fail  = 0;

    aes_rkey_store #(.DATA_W(DW), .MAX_KEYS(15), .AW(AW)) dut (
        .clk(clk), .resetn(resetn), .clr(clr), .key_len(key_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_req(rd_req), .rd_addr(rd_addr),
`ifdef RKEY_REVERSE_RD_EN
        .rd_dir(rd_dir),
`endif
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err),
        .full(full), .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] key(input int i);
        key = {96'h0000_CAFE_0000_BEEF_0000_F00D, 32'(i)};
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; outputs are then sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [DW-1:0] k);
        wr_valid = 1'b1;
        wr_data  = k;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic load(input int n, input int base);
        for (int i = 0; i < n; i++) wr(key(base + i));
    endtask

    task automatic rd_chk(input string tag, input logic [AW-1:0] a,
                          input logic e_err, input logic [DW-1:0] e_data);
        rd_req  = 1'b1;
        rd_addr = a;
        step();
        rd_req  = 1'b0;
        chk({tag, "_vld"}, DW'(rd_valid), DW'(1));
        chk({tag, "_err"}, DW'(rd_err), DW'(e_err));
        chk({tag, "_dat"}, rd_data, e_data);
    endtask

    initial begin
        // Reset state
        step(); step();
        chk("rst_count", DW'(count), DW'(0));
        chk("rst_full", DW'(full), DW'(0));
        chk("rst_rvld", DW'(rd_valid), DW'(0));
        chk("rst_rerr", DW'(rd_err), DW'(0));
        chk("rst_rdat", rd_data, '0);
        chk("rst_wrdy", DW'(wr_ready), DW'(0));
        resetn = 1'b1;
        step();
        chk("post_rst_wrdy", DW'(wr_ready), DW'(1));

        // AES-128: later key_len changes are ignored; the store fills at 11 keys
        key_len = 2'b00;
        wr(key(0));
        chk("a128_cnt1", DW'(count), DW'(1));
        key_len = 2'b10;
        load(9, 1);
        chk("a128_cnt10", DW'(count), DW'(10));
        chk("a128_nfull10", DW'(full), DW'(0));
        wr(key(10));
        chk("a128_full", DW'(full), DW'(1));
        chk("a128_cnt11", DW'(count), DW'(11));
        chk("a128_wrdy0", DW'(wr_ready), DW'(0));
        wr(key(99));
        chk("a128_drop_cnt", DW'(count), DW'(11));
        rd_chk("a128_rd10", 4'd10, 1'b0, key(10));
        rd_chk("a128_rd11", 4'd11, 1'b1, '0);
        // Back-to-back reads
        rd_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rd_addr = AW'(i);
            step();
            chk("b2b_vld", DW'(rd_valid), DW'(1));
            chk("b2b_dat", rd_data, key(i));
        end
        rd_req = 1'b0;
        step();
        chk("b2b_vld_drop", DW'(rd_valid), DW'(0));
        chk("b2b_hold", rd_data, key(2));

        // clr, with a read in the same cycle
        clr = 1'b1; rd_req = 1'b1; rd_addr = 4'd0;
        #1;
        chk("clr_wrdy", DW'(wr_ready), DW'(0));
        step();
        clr = 1'b0; rd_req = 1'b0;
        chk("clr_rd_err", DW'(rd_err), DW'(1));
        chk("clr_rd_dat", rd_data, '0);
        chk("clr_cnt", DW'(count), DW'(0));
        chk("clr_full", DW'(full), DW'(0));
        rd_chk("clr_rd0", 4'd0, 1'b1, '0);

        // AES-256: the store fills at 15 keys
        key_len = 2'b10;
        load(14, 100);
        chk("a256_nfull14", DW'(full), DW'(0));
        wr(key(114));
        chk("a256_full", DW'(full), DW'(1));
        chk("a256_cnt", DW'(count), DW'(15));
        rd_chk("a256_rd14", 4'd14, 1'b0, key(114));

        // A read in the same cycle as a write sees the count from before the write
        clr = 1'b1; step(); clr = 1'b0;
        key_len = 2'b00;
        load(3, 200);
        chk("sim_cnt3", DW'(count), DW'(3));
        wr_valid = 1'b1; wr_data = key(203);
        rd_req = 1'b1; rd_addr = 4'd3;
        step();
        wr_valid = 1'b0; rd_req = 1'b0;
        chk("sim_err", DW'(rd_err), DW'(1));
        chk("sim_dat", rd_data, '0);
        chk("sim_cnt4", DW'(count), DW'(4));
        rd_chk("sim_rd3", 4'd3, 1'b0, key(203));

        // clr in the middle of a load
        wr(key(204));
        chk("mid_cnt5", DW'(count), DW'(5));
        clr = 1'b1; step(); clr = 1'b0;
        chk("mid_cnt0", DW'(count), DW'(0));
        chk("mid_full", DW'(full), DW'(0));
        rd_chk("mid_rd0", 4'd0, 1'b1, '0);
        wr(key(300));
        rd_chk("mid_rd1_zeroed", 4'd1, 1'b1, '0);
        rd_chk("mid_rd0_new", 4'd0, 1'b0, key(300));

        // Reset while reads are in flight
        rd_req = 1'b1; rd_addr = 4'd0;
        step();
        chk("rr_vld_pre", DW'(rd_valid), DW'(1));
        resetn = 1'b0;
        #1;
        chk("rr_vld_in", DW'(rd_valid), DW'(0));
        step();
        rd_req = 1'b0;
        resetn = 1'b1;
        step();
        chk("rr_vld_post", DW'(rd_valid), DW'(0));
        chk("rr_err_post", DW'(rd_err), DW'(0));
        chk("rr_dat_post", rd_data, '0);
        chk("rr_cnt_post", DW'(count), DW'(0));
        chk("rr_full_post", DW'(full), DW'(0));

`ifdef RKEY_REVERSE_RD_EN
        // Reverse (decryption-order) reads
        key_len = 2'b00;
        load(11, 0);
        rd_dir = 1'b1;
        rd_chk("rev_rd0", 4'd0, 1'b0, key(10));
        rd_chk("rev_rd10", 4'd10, 1'b0, key(0));
        rd_chk("rev_rd11", 4'd11, 1'b1, '0);
        rd_dir = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end
endmodule
